// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
//   Shared definitions for the bit-serial subtractor.
//   - sub_state_e : controller state encoding (IDLE / RUN / DONE)
//   - SUB_WIDTH   : default operand/result width
// -----------------------------------------------------------------------------
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam int SUB_WIDTH = 4;

endpackage : sub_pkg

// File: rtl/serial_subtractor_sub1.sv
// -----------------------------------------------------------------------------
// sub1
//   One-bit full subtractor cell, purely combinational: x - y - bin.
//   Ports:
//     x    in  1  minuend bit
//     y    in  1  subtrahend bit
//     bin  in  1  borrow in
//     d    out 1  difference bit
//     bout out 1  borrow out
// -----------------------------------------------------------------------------
module sub1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x outright, or when they are equal and a borrow ripples in.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : sub1

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. Computes diff = a - b LSB-first, one bit
//   per clock, through a single sub1 cell. Valid/ready handshake on both sides.
//   Accept on edge E0, out_valid rises on edge E0+WIDTH, one op per WIDTH+2
//   cycles (DONE -> IDLE costs one bubble).
//
//   Optional feature macro: SUB_OVERFLOW_EN adds the registered signed
//   overflow output; when undefined the port and its logic are absent.
//
//   Ports:
//     clk       in  1      clock, rising edge
//     rst       in  1      synchronous active-high reset
//     in_valid  in  1      operands valid
//     in_ready  out 1      operands accepted this cycle (IDLE and not in reset)
//     a         in  WIDTH  minuend
//     b         in  WIDTH  subtrahend
//     out_valid out 1      result valid
//     out_ready in  1      consumer takes result
//     diff      out WIDTH  a - b mod 2^WIDTH
//     borrow    out 1      1 iff a < b (unsigned)
//     overflow  out 1      signed overflow (SUB_OVERFLOW_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    sub_state_e       state_r;
    sub_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic             bin_r;
    logic             borrow_r;
    logic             out_valid_r;
    logic             last_s;
    logic             d_s;
    logic             bout_s;
`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are kept aside because the shift registers lose them.
    logic             a_msb_r;
    logic             b_msb_r;
    logic             overflow_r;
`endif

    assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

    // The single cell always looks at the current LSB of the shifting operands.
    sub1 u_cell (
        .x    (a_sh_r[0]),
        .y    (b_sh_r[0]),
        .bin  (bin_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, bit counter, borrow flop and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            diff_r      <= '0;
            bin_r       <= 1'b0;
            borrow_r    <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            overflow_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        cnt_r   <= '0;
                        bin_r   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    // After WIDTH shifts bit 0's result has reached the LSB.
                    diff_r <= {d_s, diff_r[WIDTH-1:1]};
                    bin_r  <= bout_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        borrow_r    <= bout_s;
                        out_valid_r <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                        // d_s here is the MSB of the final difference.
                        overflow_r  <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign borrow    = borrow_r;
`ifdef SUB_OVERFLOW_EN
    assign overflow  = overflow_r;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        int           hold;
    } vec_t;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SUB_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] d, output logic br, output logic ov);
        int ux, uy, sx, sy, r;
        ux = int'(x);
        uy = int'(y);
        r  = ux - uy;
        d  = W'((r + (1 << W)) % (1 << W));
        br = (ux < uy);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        r  = sx - sy;
        ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int hold,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tbv;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        check("in_ready_run", in_ready, 0);
        wait_out(n);
        check("latency", n, W);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
`ifdef SUB_OVERFLOW_EN
        check("overflow", overflow, eo);
`else
        if (eo === 1'bx) $display("note: unexpected x in overflow expectation");
`endif
        check("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_diff", diff, ed);
            check("hold_borrow", borrow, eb);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
    endtask

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] md;
        logic         mb;
        logic         mo;
        int           n;

        vecs[0] = '{4'h9, 4'h3, 4'h6, 1'b0, 1'b1, 0};
        vecs[1] = '{4'h3, 4'h9, 4'hA, 1'b1, 1'b1, 1};
        vecs[2] = '{4'h0, 4'h1, 4'hF, 1'b1, 1'b0, 0};
        vecs[3] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 5};
        vecs[4] = '{4'h7, 4'h2, 4'h5, 1'b0, 1'b0, 2};
        vecs[5] = '{4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 0};
        vecs[6] = '{4'h7, 4'hF, 4'h8, 1'b1, 1'b1, 1};
        vecs[7] = '{4'h5, 4'h2, 4'h3, 1'b0, 1'b0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_in_ready", in_ready, 0);
`ifdef SUB_OVERFLOW_EN
        check("rst_overflow", overflow, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].d, vecs[i].br, vecs[i].ov);
        end

        // Back-to-back: in_valid held high, out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 4'hF;
        b         = 4'hF;
        @(negedge clk);
        a = 4'h6;
        b = 4'h9;
        wait_out(n);
        check("b2b_latency1", n, W);
        check("b2b_diff1", diff, 4'h0);
        check("b2b_borrow1", borrow, 1'b0);
        check("b2b_no_accept", in_ready, 0);
        @(negedge clk);
        check("b2b_bubble_valid", out_valid, 0);
        check("b2b_bubble_ready", in_ready, 1);
        @(negedge clk);
        check("b2b_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_out(n);
        model(4'h6, 4'h9, md, mb, mo);
        check("b2b_latency2", n, W);
        check("b2b_diff2", diff, md);
        check("b2b_borrow2", borrow, mb);
`ifdef SUB_OVERFLOW_EN
        check("b2b_overflow2", overflow, mo);
`endif
        @(negedge clk);
        check("b2b_drop", out_valid, 0);
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'h5;
        b        = 4'h3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
        rst = 1'b0;
        n   = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midrst_no_valid", n, 0);
        check("midrst_idle", in_ready, 1);
        run_op(4'h7, 4'h2, 0, 4'h5, 1'b0, 1'b0);

        // Randomised against the arithmetic model.
        for (int r = 0; r < 24; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            model(ra, rb, md, mb, mo);
            run_op(ra, rb, int'($urandom_range(0, 2)), md, mb, mo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
